// File: rtl/datapath.sv
// datapath -- single-bus register datapath with an AND-only ALU.
//
// Purpose:
//   A shared 32-bit internal bus (BusMuxOut) is driven by one of PC, Zlow,
//   MDR, R2 or R3 through a fixed-priority mux. Registers MDR, Y, R1, R2 and
//   R3 load from the bus on their enable; MDR can alternatively load from
//   memory read data. The ALU computes Y & bus and the result is captured
//   into Z on every clock edge.
//
// Ports:
//   clock      in   1   system clock, rising edge active
//   clear      in   1   synchronous active-low reset
//   Mdatain    in  32   memory read data into the MDR input mux
//   Read       in   1   MDR input select: 1 = Mdatain, 0 = bus
//   PCout      in   1   bus source enable, highest priority
//   Zlowout    in   1   bus source enable
//   MDRout     in   1   bus source enable
//   R2out      in   1   bus source enable
//   R3out      in   1   bus source enable, lowest priority
//   MDRin      in   1   MDR load enable
//   Yin        in   1   Y load enable
//   R1in       in   1   R1 load enable
//   R2in       in   1   R2 load enable
//   R3in       in   1   R3 load enable
//   BusMuxOut  out 32   current bus value (combinational)
//   R1data     out 32   current R1 contents
//   R2data     out 32   current R2 contents
//   R3data     out 32   current R3 contents
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  output logic [31:0] BusMuxOut,
  output logic [31:0] R1data,
  output logic [31:0] R2data,
  output logic [31:0] R3data
);

  logic [31:0] pc;
  logic [31:0] mdr;
  logic [31:0] y;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [31:0] r3;
  logic [31:0] z_low;

  logic [31:0] bus;
  logic [31:0] mdr_mux;
  logic [31:0] alu_low;

  // Fixed-priority bus mux. Only *out enables and register contents feed it,
  // so no load enable can reach the bus combinationally.
  always_comb begin
    bus = '0;
    if (PCout)        bus = pc;
    else if (Zlowout) bus = z_low;
    else if (MDRout)  bus = mdr;
    else if (R2out)   bus = r2;
    else if (R3out)   bus = r3;
  end

  always_comb begin
    mdr_mux = Read ? Mdatain : bus;
  end

  // The ALU result is a zero-extended AND, so the upper half of Z is
  // constant zero and has no consumer; only the low word is stored.
  always_comb begin
    alu_low = y & bus;
  end

  // PC has no load path: it is reset to zero and simply holds.
  always_ff @(posedge clock) begin
    if (!clear) begin
      pc <= '0;
    end else begin
      pc <= pc;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      mdr <= '0;
    end else if (MDRin) begin
      mdr <= mdr_mux;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      y  <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      if (Yin)  y  <= bus;
      if (R1in) r1 <= bus;
      if (R2in) r2 <= bus;
      if (R3in) r3 <= bus;
    end
  end

  // Z has no enable: it tracks the ALU every edge.
  always_ff @(posedge clock) begin
    if (!clear) begin
      z_low <= '0;
    end else begin
      z_low <= alu_low;
    end
  end

  assign BusMuxOut = bus;
  assign R1data    = r1;
  assign R2data    = r2;
  assign R3data    = r3;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath -- self-checking bench for datapath.
//
// A behavioural model of the register file (plain variables updated from the
// register-transfer rules) runs alongside the DUT. Every cycle the bus is
// compared before the edge and R1..R3 after it. Directed sequences with
// hand-computed literal expectations are followed by randomized traffic.
module tb_datapath;

  logic        clock;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read;
  logic        PCout, Zlowout, MDRout, R2out, R3out;
  logic        MDRin, Yin, R1in, R2in, R3in;
  logic [31:0] BusMuxOut, R1data, R2data, R3data;

  datapath dut (
    .clock     (clock),
    .clear     (clear),
    .Mdatain   (Mdatain),
    .Read      (Read),
    .PCout     (PCout),
    .Zlowout   (Zlowout),
    .MDRout    (MDRout),
    .R2out     (R2out),
    .R3out     (R3out),
    .MDRin     (MDRin),
    .Yin       (Yin),
    .R1in      (R1in),
    .R2in      (R2in),
    .R3in      (R3in),
    .BusMuxOut (BusMuxOut),
    .R1data    (R1data),
    .R2data    (R2data),
    .R3data    (R3data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // out-enable bit positions: {PCout, Zlowout, MDRout, R2out, R3out}
  localparam logic [4:0] O_PC = 5'b10000, O_Z = 5'b01000, O_MDR = 5'b00100,
                         O_R2 = 5'b00010, O_R3 = 5'b00001, NONE = 5'b00000;
  // in-enable bit positions: {MDRin, Yin, R1in, R2in, R3in}
  localparam logic [4:0] I_MDR = 5'b10000, I_Y = 5'b01000, I_R1 = 5'b00100,
                         I_R2 = 5'b00010, I_R3 = 5'b00001;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // reference model state
  logic [31:0] m_pc, m_mdr, m_y, m_r1, m_r2, m_r3;
  logic [63:0] m_z;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_bus();
    if (PCout)   return m_pc;
    if (Zlowout) return m_z[31:0];
    if (MDRout)  return m_mdr;
    if (R2out)   return m_r2;
    if (R3out)   return m_r3;
    return 32'h0;
  endfunction

  task automatic drive(input logic clr, input logic rd, input logic [31:0] md,
                       input logic [4:0] outs, input logic [4:0] ins);
    clear   = clr;
    Read    = rd;
    Mdatain = md;
    {PCout, Zlowout, MDRout, R2out, R3out} = outs;
    {MDRin, Yin, R1in, R2in, R3in}         = ins;
  endtask

  // One clock: check the bus before the edge, advance the model with the
  // edge, check the visible registers after it, return at the falling edge.
  task automatic cycle();
    logic [31:0] b;
    logic [31:0] n_mdr, n_y, n_r1, n_r2, n_r3;
    logic [63:0] n_z;
    #1;
    b = model_bus();
    chk("bus", BusMuxOut, b);
    if (!clear) begin
      n_mdr = 0; n_y = 0; n_r1 = 0; n_r2 = 0; n_r3 = 0; n_z = 0;
    end else begin
      n_mdr = MDRin ? (Read ? Mdatain : b) : m_mdr;
      n_y   = Yin  ? b : m_y;
      n_r1  = R1in ? b : m_r1;
      n_r2  = R2in ? b : m_r2;
      n_r3  = R3in ? b : m_r3;
      n_z   = {32'h0, m_y & b};
    end
    @(posedge clock);
    m_pc = 32'h0;
    m_mdr = n_mdr; m_y = n_y; m_r1 = n_r1; m_r2 = n_r2; m_r3 = n_r3; m_z = n_z;
    #1;
    chk("R1data", R1data, m_r1);
    chk("R2data", R2data, m_r2);
    chk("R3data", R3data, m_r3);
    @(negedge clock);
  endtask

  // Load a register via MDR: Mdatain -> MDR, then MDR -> targets.
  task automatic load_via_mdr(input logic [31:0] v, input logic [4:0] targets);
    drive(1'b1, 1'b1, v, NONE, I_MDR);
    cycle();
    drive(1'b1, 1'b0, 32'h0, O_MDR, targets);
    cycle();
  endtask

  initial begin
    m_pc = 'x; m_mdr = 'x; m_y = 'x; m_r1 = 'x; m_r2 = 'x; m_r3 = 'x; m_z = 'x;
    drive(1'b0, 1'b0, 32'h0, NONE, NONE);
    @(negedge clock);
    // reset
    cycle();
    cycle();
    drive(1'b1, 1'b0, 32'hDEADBEEF, NONE, NONE);
    #1;
    chk("reset_bus", BusMuxOut, 32'h0);
    chk("reset_R1", R1data, 32'h0);
    chk("reset_R2", R2data, 32'h0);
    chk("reset_R3", R3data, 32'h0);
    cycle();

    // register load: Mdatain -> MDR -> R2
    load_via_mdr(32'h12, I_R2);
    chk("load_R2", R2data, 32'h12);

    // AND: R3 = 0x14, Y <- R2, Z <- Y & R3, R1 <- Zlow
    load_via_mdr(32'h14, I_R3);
    drive(1'b1, 1'b0, 32'h0, O_R2, I_Y);
    cycle();
    drive(1'b1, 1'b0, 32'h0, O_R3, NONE);
    cycle();
    drive(1'b1, 1'b0, 32'h0, O_Z, I_R1);
    #1;
    chk("and_zlow_bus", BusMuxOut, 32'h10);
    cycle();
    chk("and_R1", R1data, 32'h10);

    // priority: MDR beats R2
    drive(1'b1, 1'b1, 32'h11, NONE, I_MDR);
    cycle();
    drive(1'b1, 1'b0, 32'h0, O_MDR | O_R2, NONE);
    #1;
    chk("prio_mdr_over_r2", BusMuxOut, 32'h11);
    cycle();
    drive(1'b1, 1'b0, 32'h0, O_R2 | O_R3, NONE);
    #1;
    chk("prio_r2_over_r3", BusMuxOut, 32'h12);
    cycle();
    drive(1'b1, 1'b0, 32'h0, NONE, NONE);
    #1;
    chk("prio_idle_bus", BusMuxOut, 32'h0);
    cycle();

    // MDR from bus ignores Mdatain when Read=0
    drive(1'b1, 1'b0, 32'hFFFFFFFF, O_R3, I_MDR);
    cycle();
    drive(1'b1, 1'b0, 32'h0, O_MDR, NONE);
    #1;
    chk("mdr_from_bus", BusMuxOut, 32'h14);
    cycle();

    // self reload: R2 is source and target
    drive(1'b1, 1'b0, 32'h0, O_R2, I_R2 | I_R3);
    cycle();
    chk("self_reload_R2", R2data, 32'h12);
    chk("multi_load_R3", R3data, 32'h12);

    // reset mid-operation
    load_via_mdr(32'h18, I_R1);
    chk("pre_reset_R1", R1data, 32'h18);
    drive(1'b0, 1'b0, 32'h0, O_MDR, I_R1);
    cycle();
    chk("midreset_R1", R1data, 32'h0);
    chk("midreset_R2", R2data, 32'h0);
    chk("midreset_R3", R3data, 32'h0);
    drive(1'b1, 1'b0, 32'h0, O_MDR, NONE);
    #1;
    chk("midreset_mdr", BusMuxOut, 32'h0);
    drive(1'b1, 1'b1, 32'h5, NONE, I_MDR);
    cycle();
    drive(1'b1, 1'b0, 32'h0, O_MDR, NONE);
    #1;
    chk("resume_mdr", BusMuxOut, 32'h5);
    cycle();

    // hold for 5 edges
    load_via_mdr(32'h12, I_R2);
    drive(1'b1, 1'b0, 32'hA5A5A5A5, NONE, NONE);
    for (int i = 0; i < 5; i++) cycle();
    chk("hold_R2", R2data, 32'h12);
    drive(1'b1, 1'b0, 32'h0, O_PC, NONE);
    #1;
    chk("hold_pc", BusMuxOut, 32'h0);
    cycle();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] outs, ins;
      outs = 5'($urandom) & 5'($urandom);
      if ($urandom_range(0, 15) == 0) outs[4] = 1'b1; else outs[4] = 1'b0;
      ins  = 5'($urandom) & 5'($urandom);
      drive(($urandom_range(0, 40) != 0), 1'($urandom), $urandom, outs, ins);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have port Mdatain, input, 32 bits: memory read data presented to MDR input mux.
REQ-004 SHALL have port Read, input, 1 bit: MDR input mux select; 1 selects Mdatain, 0 selects bus.
REQ-005 SHALL have ports PCout, Zlowout, MDRout, R2out, R3out, input, 1 bit each: bus source enables.
REQ-006 SHALL have ports MDRin, Yin, R1in, R2in, R3in, input, 1 bit each: register load enables.
REQ-007 SHALL have port BusMuxOut, output, 32 bits: current internal bus value, combinational.
REQ-008 SHALL have ports R1data, R2data, R3data, output, 32 bits each: current contents of R1, R2, R3.

Function
REQ-009 SHALL contain 32-bit registers PC, MDR, Y, R1, R2, R3 and a 64-bit register Z (Zlow = Z[31:0], Zhigh = Z[63:32]).
REQ-010 SHALL drive BusMuxOut combinationally with fixed priority PCout > Zlowout > MDRout > R2out > R3out.
- Sources: PC, Zlow, MDR, R2, R3 respectively.
- No enable asserted: bus = 32'h00000000.
REQ-011 SHALL, when MDRin=1 at a rising edge, load MDR with Mdatain if Read=1, else with BusMuxOut; MDR holds when MDRin=0.
REQ-012 SHALL, when Yin/R1in/R2in/R3in=1 at a rising edge, load Y/R1/R2/R3 respectively from BusMuxOut; each holds otherwise.
REQ-013 SHALL compute ALU result combinationally as bitwise AND: Y & BusMuxOut, zero-extended to 64 bits.
REQ-014 SHALL load Z with the ALU result on every rising edge (no Z enable); Zhigh is therefore always 0.
REQ-015 SHALL hold PC at its reset value; PC has no load path in this block.
REQ-016 SHALL give all register loads one-cycle latency: the value written is visible on outputs and bus sources after that edge.
REQ-017 SHALL allow simultaneous load enables: all enabled registers capture the same bus value on the same edge.
REQ-018 SHALL allow a register to be both bus source and load target in one cycle; it reloads its own old value.
REQ-019 SHALL produce no combinational path from any load enable to BusMuxOut.

Reset
REQ-020 SHALL, on a rising edge with clear=0, set PC, MDR, Y, R1, R2, R3 to 32'h0 and Z to 64'h0, overriding all load enables.
REQ-021 SHALL keep registers at zero for every edge on which clear remains 0; normal operation resumes on the first edge with clear=1.
REQ-022 SHALL, after reset and with no enables asserted, present BusMuxOut=0 and R1data=R2data=R3data=0.

Verification
REQ-023 Register load: clear=1, Mdatain=0x12, Read=1, MDRin=1 for one edge; then MDRout=1, R2in=1 for one edge -> R2data=0x00000012.
REQ-024 AND operation: R2=0x12, R3=0x14.
- Edge with R2out=1, Yin=1 -> Y=0x12.
- Edge with R3out=1 -> Zlow=0x10.
- Edge with Zlowout=1, R1in=1 -> R1data=0x00000010.
REQ-025 Bus priority: MDR=0x11, R2=0x12, MDRout=1 and R2out=1 together -> BusMuxOut=0x11; all out enables low -> BusMuxOut=0.
REQ-026 MDR from bus: R3=0x14, R3out=1, MDRin=1, Read=0 for one edge -> MDR=0x14, regardless of Mdatain=0xFFFFFFFF.
REQ-027 Reset mid-operation: R1=0x18, clear=0 for one edge with R1in=1 and MDRout=1 -> R1data=0 and all registers 0; clear=1 next edge resumes loads.
REQ-028 Hold: R2=0x12, 5 edges with all enables low and clear=1 -> R2data stays 0x12 and PC stays 0.
